q_sys_input_pio: RTL and testbench
==================================

Name: q_sys_input_pio

Overview:
- Avalon-MM slave input PIO: the input-direction counterpart to the system's output PIOs. It samples external status lines from the fibre BPM front end into the Qsys fabric.
- Synchronises `in_port`, detects edges, latches them in a write-1-to-clear capture register and raises a maskable level interrupt to the Nios host.
- Sits on the same Avalon bus segment as the output PIOs.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 0, edge that sets capture: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 16, stable-cycle count required before a bit is accepted (used only with PIO_IN_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  3  Avalon word address
- chipselect  input  1  Avalon chipselect
- write_n  input  1  Avalon write strobe, active low
- writedata  input  32  Avalon write data
- in_port  input  WIDTH  asynchronous external inputs
- readdata  output  32  registered Avalon read data
- irq  output  1  level interrupt to host

Behaviour:
- One clock (`clk`). Reset is asynchronous, active-high (`reset`), and clears every register.
- Reset values:
  - readdata = 0, irq = 0.
  - Sync stages, filtered data, previous-sample register, edge_capture and irq_mask all 0.
  - prime counter = 0.
- Synchroniser: two flops per bit, from in_port to sync_q.
  - Filtered value `din` = sync_q (or the debounced value, see Optional Feature).
  - Latency from in_port to din: 2 clocks.
- Edge detect: `din_prev` is registered `din`.
  - rise = din & ~din_prev
  - fall = ~din & din_prev
  - any = rise | fall
  - EDGE_TYPE selects which of these is `edge_evt`.
- Prime: 2-bit counter increments after reset deassertion and saturates at 3. `edge_evt` is forced to 0 until the counter reaches 3, so inputs already high at reset raise no spurious capture.
- wr_strobe = chipselect & ~write_n.
- Register map (word address):
  - 0 data: read-only. Writes ignored. Reads zero-extended din.
  - 2 irq_mask: read/write, WIDTH bits. Write loads writedata[WIDTH-1:0].
  - 3 edge_capture: read, write-1-to-clear per bit.
  - All other addresses read 0; writes to them are ignored.
- edge_capture update per bit, each clock: next = edge_evt | (edge_capture & ~(clear_mask)).
  - clear_mask = writedata bits when wr_strobe and address==3, else 0.
  - If an edge and a clear hit the same bit in the same cycle, set wins.
- readdata is registered every clock from the mux on the current address, regardless of chipselect. The component is declared with read wait 1, so data is valid the cycle after the address is presented. Unused upper bits are 0.
- irq is registered: irq <= |(edge_capture & irq_mask).
  - Latency from edge on din to irq: 2 clocks (capture, then irq).
  - irq deasserts 1 clock after the clear write lands.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The prime sequence restarts on deassertion.
- WIDTH < 32: writedata bits at WIDTH and above are ignored.

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined: each bit has a counter of width clog2(DEBOUNCE_CYCLES+1).
  - When sync_q differs from din, the counter increments. Otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES, din takes sync_q and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES clocks never reaches din.
- Undefined: din = sync_q directly, with no counters synthesised.

Decomposition:
- Package q_sys_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3 (shared with the output PIO's 0/4/5 map);
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
- One sub-module, q_sys_pio_debounce: a per-bit synchroniser plus optional debounce, instantiated WIDTH times via generate. This keeps the top level to the register file and edge logic.

Test Plan:
- Reset with in_port=8'hFF held, release, wait 10 clocks -> edge_capture=0, irq=0; read addr0 -> 32'h000000FF.
- EDGE_TYPE=0, irq_mask=8'h01, in_port bit0 0->1 -> edge_capture=8'h01 within 3 clocks of the change, irq=1 one clock later; write 32'h1 to addr3 -> irq=0 next clock.
- Write-1-to-clear collision: clear bit2 on the same clock that a bit2 rise reaches edge_detect -> edge_capture bit2 remains 1.
- irq_mask=0, pulse bits 3 and 5 -> edge_capture=8'h28, irq stays 0; write mask 8'h20 -> irq=1; write 32'h20 to addr3 -> irq=0, edge_capture=8'h08.
- EDGE_TYPE=2, toggle bit7 high then low with a capture clear between -> capture set on both transitions; write to addr0 and addr6 -> no state change; read addr6 -> 0.
- With PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - a 10-clock pulse on bit0 -> no capture, data reads 0;
  - a 20-clock pulse -> capture set, data reads 1 after 2+16 clocks.

Source files
------------

// File: rtl/q_sys_pio_pkg.sv
// -----------------------------------------------------------------------------
// q_sys_pio_pkg
// Shared definitions for the Qsys PIO components. The input PIO uses word
// addresses 0/2/3. The output PIOs use 0/4/5 for data/set/clear on the same
// bus segment.
//
// Contents:
//   PIO_ADDR_*  Avalon word addresses of the input PIO registers
//   edge_type_e encodings for the EDGE_TYPE parameter
//   PRIME_DONE  saturation value of the post-reset prime counter
// -----------------------------------------------------------------------------
package q_sys_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  localparam logic [1:0] PRIME_DONE = 2'd3;

endpackage

// File: rtl/q_sys_pio_debounce.sv
// -----------------------------------------------------------------------------
// q_sys_pio_debounce
// Single-bit input conditioner. A two-flop synchroniser is followed by an
// optional stable-time filter.
//
// Build option:
//   PIO_IN_DEBOUNCE_EN  When defined, a change on the synchronised input only
//                       reaches q after it has held for DEBOUNCE_CYCLES
//                       clocks. When undefined, q is the synchroniser output
//                       and no counter exists.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   d      asynchronous external input
//   q      conditioned value (din for this bit)
// -----------------------------------------------------------------------------
module q_sys_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("q_sys_pio_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic meta;
  logic sync_q;

  // NOTE: flops use non-blocking assignments and an async reset term in the
  // sensitivity list. A blocking assignment here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= d;
      sync_q <= meta;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          din_q;

  // The count advances while the synchronised input disagrees with the
  // accepted value. The increment that reaches DEBOUNCE_CYCLES accepts the
  // new value instead, so a level that holds N clocks lands N clocks after
  // it leaves the synchroniser. Any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      din_q <= 1'b0;
    end else if (sync_q != din_q) begin
      if (cnt == CNT_LAST) begin
        din_q <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign q = din_q;
`else
  assign q = sync_q;
`endif

endmodule

// File: rtl/q_sys_input_pio.sv
// -----------------------------------------------------------------------------
// q_sys_input_pio
// Avalon-MM slave input PIO. It samples status lines from the fibre BPM front
// end, latches the selected edges into a write-1-to-clear capture register,
// and raises a maskable level interrupt to the Nios host.
//
// Register map (word address):
//   0  data          RO   zero-extended conditioned input (din)
//   2  irq_mask      RW   WIDTH bits
//   3  edge_capture  R/W1C
//   All other addresses read 0 and ignore writes.
// readdata is registered from the address every clock (read wait 1).
//
// Build option: PIO_IN_DEBOUNCE_EN enables per-bit debounce in
// q_sys_pio_debounce.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     Avalon word address
//   chipselect  Avalon chipselect
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   in_port     asynchronous external inputs
//   readdata    registered Avalon read data
//   irq         level interrupt to host
// -----------------------------------------------------------------------------
module q_sys_input_pio
  import q_sys_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("q_sys_input_pio: WIDTH must be 1..32");
  end

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_prev;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [1:0]       prime_cnt;
  logic             wr_strobe;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_in
    q_sys_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .reset(reset),
      .d    (in_port[i]),
      .q    (din[i])
    );
  end

  assign wr_strobe = chipselect & ~write_n;

  // Bits of writedata at WIDTH and above have no register behind them.
  assign unused_wdata = ^writedata;

  // NOTE: every signal written in an always_comb block gets a default at the
  // top. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    edge_raw = din ^ din_prev;
    case (EDGE_SEL)
      EDGE_RISE: edge_raw = din & ~din_prev;
      EDGE_FALL: edge_raw = ~din & din_prev;
      default:   edge_raw = din ^ din_prev;
    endcase
  end

  // After reset, din_prev lags din by a clock. The prime count holds off
  // capture until both have settled, so lines that are already high at
  // reset do not register an edge.
  assign edge_evt   = (prime_cnt == PRIME_DONE) ? edge_raw : '0;
  assign clear_mask = (wr_strobe && address == PIO_ADDR_EDGECAP)
                      ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = din;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_prev     <= '0;
      prime_cnt    <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      din_prev <= din;
      if (prime_cnt != PRIME_DONE) prime_cnt <= prime_cnt + 2'd1;
      // A new edge sets its bit even if a clear for that bit lands on the
      // same clock.
      edge_capture <= edge_evt | (edge_capture & ~clear_mask);
      if (wr_strobe && address == PIO_ADDR_IRQMASK)
        irq_mask <= writedata[WIDTH-1:0];
      irq      <= |(edge_capture & irq_mask);
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_q_sys_input_pio.sv
// -----------------------------------------------------------------------------
// tb_q_sys_input_pio
// Directed bench for q_sys_input_pio in its default build. Two instances
// share the bus and inputs. dut_r captures rising edges. dut_a captures any
// edge. Inputs change on the falling clock edge, and outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_q_sys_input_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata_r, readdata_a;
  logic        irq_r, irq_a;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_r, rd_a;

  always #5 clk = ~clk;

  q_sys_input_pio #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_r), .irq(irq_r)
  );

  q_sys_input_pio #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a read, let readdata register on the next rising edge, then
  // sample both instances.
  task automatic bus_read(input logic [2:0] addr);
    address = addr; chipselect = 1'b1; write_n = 1'b1;
    tick();
    rd_r = readdata_r; rd_a = readdata_a;
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_port = 8'hFF; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (2) tick();
    n_vec++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin $display("FAIL reset_irq: got %b/%b want 0/0", irq_r, irq_a); n_err++; end
    n_vec++; if (readdata_r !== 32'h0) begin $display("FAIL reset_readdata: got %h want 00000000", readdata_r); n_err++; end
    reset = 1'b0;
    repeat (10) tick();
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h0) begin $display("FAIL reset_cap_rise: got %h want 00000000", rd_r); n_err++; end
    n_vec++; if (rd_a !== 32'h0) begin $display("FAIL reset_cap_any: got %h want 00000000", rd_a); n_err++; end
    n_vec++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin $display("FAIL reset_irq_after: got %b/%b want 0/0", irq_r, irq_a); n_err++; end
    bus_read(3'd0);
    n_vec++; if (rd_r !== 32'h000000FF) begin $display("FAIL reset_data: got %h want 000000ff", rd_r); n_err++; end
    // Drop the inputs. The fall is captured by dut_a, so clear it.
    in_port = 8'h00;
    repeat (4) tick();
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read(3'd3);
    n_vec++; if (rd_a !== 32'h0) begin $display("FAIL reset_cleanup: got %h want 00000000", rd_a); n_err++; end
  endtask

  task automatic test_rise_irq();
    bus_write(3'd2, 32'h1);
    in_port = 8'h01;
    repeat (3) tick();
    n_vec++; if (irq_r !== 1'b0) begin $display("FAIL rise_irq_early: got %b want 0", irq_r); n_err++; end
    tick();
    n_vec++; if (irq_r !== 1'b1) begin $display("FAIL rise_irq_set: got %b want 1", irq_r); n_err++; end
    n_vec++; if (irq_a !== 1'b1) begin $display("FAIL rise_irq_set_any: got %b want 1", irq_a); n_err++; end
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h01) begin $display("FAIL rise_cap: got %h want 00000001", rd_r); n_err++; end
    bus_write(3'd3, 32'h1);
    n_vec++; if (irq_r !== 1'b1) begin $display("FAIL clear_irq_hold: got %b want 1", irq_r); n_err++; end
    tick();
    n_vec++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin $display("FAIL clear_irq_drop: got %b/%b want 0/0", irq_r, irq_a); n_err++; end
  endtask

  task automatic test_collision();
    in_port = 8'h05;
    repeat (4) tick();
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h04) begin $display("FAIL coll_pre: got %h want 00000004", rd_r); n_err++; end
    in_port = 8'h01;
    repeat (4) tick();
    // The rise reaches edge detect on the third rising clock. The clear
    // write lands on that same edge.
    in_port = 8'h05;
    repeat (2) tick();
    bus_write(3'd3, 32'h04);
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h04) begin $display("FAIL coll_set_wins: got %h want 00000004", rd_r); n_err++; end
    n_vec++; if (rd_a !== 32'h04) begin $display("FAIL coll_set_wins_any: got %h want 00000004", rd_a); n_err++; end
    bus_write(3'd3, 32'h04);
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h0 || rd_a !== 32'h0) begin $display("FAIL coll_clear: got %h/%h want 0/0", rd_r, rd_a); n_err++; end
  endtask

  task automatic test_mask();
    bus_write(3'd2, 32'h0);
    in_port = 8'h2D;
    repeat (4) tick();
    in_port = 8'h05;
    repeat (4) tick();
    n_vec++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin $display("FAIL mask_irq_off: got %b/%b want 0/0", irq_r, irq_a); n_err++; end
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h28) begin $display("FAIL mask_cap: got %h want 00000028", rd_r); n_err++; end
    n_vec++; if (rd_a !== 32'h28) begin $display("FAIL mask_cap_any: got %h want 00000028", rd_a); n_err++; end
    bus_write(3'd2, 32'h20);
    tick();
    n_vec++; if (irq_r !== 1'b1) begin $display("FAIL mask_irq_on: got %b want 1", irq_r); n_err++; end
    bus_write(3'd3, 32'h20);
    tick();
    n_vec++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin $display("FAIL mask_irq_clr: got %b/%b want 0/0", irq_r, irq_a); n_err++; end
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h08 || rd_a !== 32'h08) begin $display("FAIL mask_cap_left: got %h/%h want 8/8", rd_r, rd_a); n_err++; end
  endtask

  task automatic test_any_edge();
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h80);
    in_port = 8'h85;
    repeat (4) tick();
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h80 || rd_a !== 32'h80) begin $display("FAIL any_rise: got %h/%h want 80/80", rd_r, rd_a); n_err++; end
    bus_write(3'd3, 32'h80);
    in_port = 8'h05;
    repeat (4) tick();
    bus_read(3'd3);
    n_vec++; if (rd_r !== 32'h00) begin $display("FAIL rise_ignores_fall: got %h want 00000000", rd_r); n_err++; end
    n_vec++; if (rd_a !== 32'h80) begin $display("FAIL any_fall: got %h want 00000080", rd_a); n_err++; end
    n_vec++; if (irq_r !== 1'b0 || irq_a !== 1'b1) begin $display("FAIL any_irq: got %b/%b want 0/1", irq_r, irq_a); n_err++; end
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd3);
    n_vec++; if (rd_a !== 32'h80) begin $display("FAIL ro_write_cap: got %h want 00000080", rd_a); n_err++; end
    bus_read(3'd2);
    n_vec++; if (rd_a !== 32'h80) begin $display("FAIL ro_write_mask: got %h want 00000080", rd_a); n_err++; end
    bus_read(3'd0);
    n_vec++; if (rd_r !== 32'h05) begin $display("FAIL data_read: got %h want 00000005", rd_r); n_err++; end
    bus_read(3'd6);
    n_vec++; if (rd_r !== 32'h0 || rd_a !== 32'h0) begin $display("FAIL addr6_read: got %h/%h want 0/0", rd_r, rd_a); n_err++; end
    // Bits of the mask write above WIDTH are dropped, so this clears the mask.
    bus_write(3'd2, 32'hFFFF_FF00);
    tick();
    n_vec++; if (irq_a !== 1'b0) begin $display("FAIL wide_mask_irq: got %b want 0", irq_a); n_err++; end
    bus_read(3'd2);
    n_vec++; if (rd_a !== 32'h0) begin $display("FAIL wide_mask_read: got %h want 00000000", rd_a); n_err++; end
  endtask

  task automatic test_reset_mid();
    bus_write(3'd2, 32'h80);
    tick();
    n_vec++; if (irq_a !== 1'b1) begin $display("FAIL mid_irq_pre: got %b want 1", irq_a); n_err++; end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (irq_a !== 1'b0) begin $display("FAIL mid_irq_async: got %b want 0", irq_a); n_err++; end
    n_vec++; if (readdata_a !== 32'h0) begin $display("FAIL mid_readdata_async: got %h want 00000000", readdata_a); n_err++; end
    tick();
    reset = 1'b0;
    repeat (10) tick();
    bus_read(3'd3);
    n_vec++; if (rd_a !== 32'h0 || rd_r !== 32'h0) begin $display("FAIL mid_cap: got %h/%h want 0/0", rd_r, rd_a); n_err++; end
    bus_read(3'd2);
    n_vec++; if (rd_a !== 32'h0) begin $display("FAIL mid_mask: got %h want 00000000", rd_a); n_err++; end
    bus_read(3'd0);
    n_vec++; if (rd_r !== 32'h05) begin $display("FAIL mid_data: got %h want 00000005", rd_r); n_err++; end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_collision();
    test_mask();
    test_any_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
